// File: rtl/melody_trigger_ctrl.sv
// Piezo melody request stage: merges button and event requests into timed start windows.
// Optional macro BTN_DEBOUNCE_EN: defined adds the button debounce counter.
module melody_trigger_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 20000,
    parameter int unsigned HOLD_CYC     = 4100000,
    parameter int unsigned GAP_CYC      = 1000,
    parameter int unsigned MAX_PEND     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       event_pulse,
    input  logic       enable,
    output logic       start_melody,
    output logic       busy,
    output logic [1:0] pending,
    output logic       overflow
);

    localparam int unsigned MaxHg  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CntMax = (MaxHg > DEBOUNCE_CYC) ? MaxHg : DEBOUNCE_CYC;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYC - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [1:0]      PendMax  = 2'(MAX_PEND);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            launch;

    logic            sync1_q, sync2_q;
    logic            level_prev_q;
    logic            db_level;
    logic            btn_req;
    logic            req;

    logic [1:0]      pending_q, pending_d;
    logic            overflow_q, overflow_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;

    // Button synchronizer and edge-detect history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= btn_in;
            sync2_q      <= sync1_q;
            level_prev_q <= db_level;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYC - 1);

    logic [CntW-1:0] db_cnt_q, db_cnt_d;
    logic            db_level_q, db_level_d;

    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DbLast) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
        end
    end

    assign db_level = db_level_q;
`else
    assign db_level = sync2_q;
`endif

    // Only presses request playback; releases are ignored
    assign btn_req = db_level & ~level_prev_q;
    assign req     = btn_req | event_pulse;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state; enable only gates launching, never shortens a window
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && (pending_q != 2'd0)) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    launch  = 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs, decoded from the next state so they flip with the state register
    always_comb begin
        start_d = (state_d == StHold);
        busy_d  = (state_d != StIdle);
    end

    // Pending counter: saturating, launch consumes one entry
    always_comb begin
        pending_d  = pending_q;
        overflow_d = 1'b0;
        if (!enable) begin
            pending_d = 2'd0;
        end else if (req && !launch) begin
            if (pending_q == PendMax) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 2'd1;
            end
        end else if (!req && launch) begin
            pending_d = pending_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= 2'd0;
            overflow_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    assign start_melody = start_q;
    assign busy         = busy_q;
    assign pending      = pending_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_melody_trigger_ctrl.sv
// Scoreboard bench for melody_trigger_ctrl: expected window starts and overflow pulses are
// queued by the stimulus and checked by an independent output monitor.
module tb_melody_trigger_ctrl;

    localparam int unsigned DebCyc  = 4;
    localparam int unsigned HoldCyc = 20;
    localparam int unsigned GapCyc  = 5;
    localparam int unsigned MaxPend = 3;
    localparam int WinSpacing = HoldCyc + GapCyc + 1;
`ifdef BTN_DEBOUNCE_EN
    localparam int BtnLat = 3 + DebCyc;
`else
    localparam int BtnLat = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic       event_pulse = 1'b0;
    logic       enable = 1'b1;
    logic       start_melody;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int exp_win[$];
    int exp_ovf[$];

    melody_trigger_ctrl #(
        .DEBOUNCE_CYC(DebCyc),
        .HOLD_CYC    (HoldCyc),
        .GAP_CYC     (GapCyc),
        .MAX_PEND    (MaxPend)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .event_pulse (event_pulse),
        .enable      (enable),
        .start_melody(start_melody),
        .busy        (busy),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(output int e);
        event_pulse = 1'b1;
        tick();
        e = cyc;
        event_pulse = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!(busy == 1'b0 && start_melody == 1'b0 && pending == 2'd0) && k < 300) begin
            tick();
            k++;
        end
        check(name, int'(k < 300), 1);
        repeat (2) tick();
    endtask

    // Output monitor
    int  hi_cnt = 0;
    int  gap_cnt = 0;
    bit  in_hi = 0;
    bit  in_gap = 0;
    bit  prev_sm = 0;

    always @(negedge clk) begin
        int e;
        if (rst) begin
            in_hi   = 0;
            in_gap  = 0;
            prev_sm = 0;
        end else begin
            if (start_melody && !prev_sm) begin
                if (exp_win.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL win_unexpected: window at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_win.pop_front();
                    check("win_start_cycle", cyc, e);
                end
                check("win_busy", int'(busy), 1);
                in_hi  = 1;
                hi_cnt = 0;
            end
            if (in_hi && start_melody) hi_cnt++;
            if (in_hi && !start_melody) begin
                check("win_len", hi_cnt, HoldCyc);
                in_hi   = 0;
                in_gap  = 1;
                gap_cnt = 0;
            end
            if (in_gap) begin
                if (busy) begin
                    gap_cnt++;
                end else begin
                    check("gap_len", gap_cnt, GapCyc);
                    in_gap = 0;
                end
            end
            if (overflow) begin
                if (exp_ovf.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ovf_unexpected: overflow at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_ovf.pop_front();
                    check("ovf_cycle", cyc, e);
                end
            end
            prev_sm = start_melody;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_start", int'(start_melody), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_overflow", int'(overflow), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Single event
        pulse(n);
        exp_win.push_back(n + 1);
        check("single_pend_N", int'(pending), 1);
        check("single_start_N", int'(start_melody), 0);
        tick();
        check("single_start_N1", int'(start_melody), 1);
        check("single_pend_N1", int'(pending), 0);
        wait_idle("single_idle");

        // Reset in the middle of HOLD, with a request queued
        pulse(n);
        exp_win.push_back(n + 1);
        tick();
        tick();
        pulse(e);
        check("rstmid_pend_before", int'(pending), 1);
        while (cyc < n + 10) tick();
        #2 rst = 1'b1;
        #1;
        check("rstmid_start", int'(start_melody), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_pending", int'(pending), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("rstmid_after_start", int'(start_melody), 0);
        check("rstmid_after_busy", int'(busy), 0);
        check("rstmid_after_pending", int'(pending), 0);

        // Saturation: five requests during one HOLD
        pulse(n);
        for (int k = 0; k < 4; k++) exp_win.push_back(n + 1 + k * WinSpacing);
        tick();
        tick();
        pulse(e);
        check("sat_pend_1", int'(pending), 1);
        tick();
        pulse(e);
        check("sat_pend_2", int'(pending), 2);
        tick();
        pulse(e);
        check("sat_pend_3", int'(pending), 3);
        tick();
        exp_ovf.push_back(cyc + 1);
        pulse(e);
        check("sat_pend_4", int'(pending), 3);
        tick();
        exp_ovf.push_back(cyc + 1);
        pulse(e);
        check("sat_pend_5", int'(pending), 3);
        wait_idle("sat_idle");

        // Request on the launch edge
        pulse(n);
        exp_win.push_back(n + 1);
        exp_win.push_back(n + 1 + WinSpacing);
        pulse(e);
        check("launch_req_pend", int'(pending), 1);
        check("launch_req_start", int'(start_melody), 1);
        wait_idle("launch_req_idle");

        // Button request coincident with event_pulse counts once
        btn_in = 1'b1;
        repeat (BtnLat - 1) tick();
        exp_win.push_back(cyc + 2);
        pulse(e);
        check("merge_pend", int'(pending), 1);
        tick();
        btn_in = 1'b0;
        repeat (12) tick();
        wait_idle("merge_idle");

`ifdef BTN_DEBOUNCE_EN
        // Bouncing press: one request after the final rise
        for (int k = 0; k < 20; k++) begin
            btn_in = ((k / 2) % 2 == 0);
            tick();
        end
        btn_in = 1'b1;
        exp_win.push_back(cyc + BtnLat + 1);
        repeat (BtnLat + 2) tick();
        wait_idle("bounce_idle");
        btn_in = 1'b0;
        repeat (12) tick();
        check("release_pend", int'(pending), 0);
        // Short glitch is filtered
        btn_in = 1'b1;
        repeat (3) tick();
        btn_in = 1'b0;
        repeat (12) tick();
        check("glitch_pend", int'(pending), 0);
        check("glitch_busy", int'(busy), 0);
`else
        // Clean press without debounce
        btn_in = 1'b1;
        exp_win.push_back(cyc + BtnLat + 1);
        repeat (BtnLat + 2) tick();
        wait_idle("press_idle");
        btn_in = 1'b0;
        repeat (6) tick();
        check("release_pend", int'(pending), 0);
        check("release_busy", int'(busy), 0);
`endif

        // enable dropped during HOLD with requests pending
        pulse(n);
        exp_win.push_back(n + 1);
        tick();
        tick();
        pulse(e);
        tick();
        pulse(e);
        check("en_pend_2", int'(pending), 2);
        tick();
        enable = 1'b0;
        tick();
        check("en_pend_clr", int'(pending), 0);
        check("en_start_kept", int'(start_melody), 1);
        while (cyc < n + 20) tick();
        check("en_hold_last", int'(start_melody), 1);
        tick();
        check("en_hold_end", int'(start_melody), 0);
        check("en_gap_busy", int'(busy), 1);
        wait_idle("en_idle");
        pulse(e);
        check("en0_pend", int'(pending), 0);
        check("en0_ovf", int'(overflow), 0);
        repeat (3) tick();
        enable = 1'b1;
        repeat (4) tick();
        check("en_restore_busy", int'(busy), 0);
        check("en_restore_pend", int'(pending), 0);

        repeat (5) tick();
        check("win_queue_empty", exp_win.size(), 0);
        check("ovf_queue_empty", exp_ovf.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
